// File: rtl/des_pkg.sv
// Shared DES key-path definitions: permuted-choice tables, rotation schedules,
// FSM state type and 28-bit rotation helpers.
package des_pkg;

  typedef logic [27:0] half_t;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  // FIPS 1-based key bit numbers; entry j feeds PC1 output bit j+1
  localparam logic [6:0] PC1_TAB [0:55] = '{
    7'd57, 7'd49, 7'd41, 7'd33, 7'd25, 7'd17, 7'd9,
    7'd1,  7'd58, 7'd50, 7'd42, 7'd34, 7'd26, 7'd18,
    7'd10, 7'd2,  7'd59, 7'd51, 7'd43, 7'd35, 7'd27,
    7'd19, 7'd11, 7'd3,  7'd60, 7'd52, 7'd44, 7'd36,
    7'd63, 7'd55, 7'd47, 7'd39, 7'd31, 7'd23, 7'd15,
    7'd7,  7'd62, 7'd54, 7'd46, 7'd38, 7'd30, 7'd22,
    7'd14, 7'd6,  7'd61, 7'd53, 7'd45, 7'd37, 7'd29,
    7'd21, 7'd13, 7'd5,  7'd28, 7'd20, 7'd12, 7'd4
  };

  // 1-based {C,D} bit numbers; entry j feeds subkey bit j+1
  localparam logic [5:0] PC2_TAB [0:47] = '{
    6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
    6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
    6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
    6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
    6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
    6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
    6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
    6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
  };

  localparam logic [1:0] ENC_SHIFT [0:15] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  // Entry 0 is unused: decrypt starts from the unrotated C0/D0, which is K16
  localparam logic [1:0] DEC_SHIFT [0:15] = '{
    2'd0, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  function automatic half_t rotl(input half_t h, input logic [1:0] n);
    case (n)
      2'd1:    rotl = {h[26:0], h[27]};
      2'd2:    rotl = {h[25:0], h[27:26]};
      default: rotl = h;
    endcase
  endfunction

  function automatic half_t rotr(input half_t h, input logic [1:0] n);
    case (n)
      2'd1:    rotr = {h[0], h[27:1]};
      2'd2:    rotr = {h[1:0], h[27:2]};
      default: rotr = h;
    endcase
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Permuted choice 2: pure wiring from the 56-bit {C,D} state to a 48-bit subkey.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd,
  output logic [47:0] subkey
);

  for (genvar j = 0; j < 48; j++) begin : g_bit
    localparam int SRC = 56 - int'(PC2_TAB[j]);
    assign subkey[47-j] = cd[SRC];
  end

endmodule

// File: rtl/des_key_schedule.sv
// Iterative DES subkey generator: one subkey per valid/ready handshake,
// K1..K16 for encrypt (left rotations) or K16..K1 for decrypt (right rotations).
module des_key_schedule
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] key_in,
  input  logic        start,
  input  logic        decrypt,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        busy,
  output logic        done
);

  localparam logic [3:0] LAST_ROUND = 4'(NUM_ROUNDS - 1);

  state_t      state_r;
  half_t       c_r;
  half_t       d_r;
  logic [3:0]  round_r;
  logic        mode_r;
  logic        done_r;

  logic [55:0] pc1_s;
  half_t       pc1_c_s;
  half_t       pc1_d_s;
  logic [3:0]  next_round_s;
  logic [1:0]  shift_s;
  logic [47:0] pc2_s;

  // PC1 drops the eight parity bits, so they never reach C/D
  for (genvar j = 0; j < 56; j++) begin : g_pc1
    localparam int SRC = 64 - int'(PC1_TAB[j]);
    assign pc1_s[55-j] = key_in[SRC];
  end

  assign pc1_c_s = pc1_s[55:28];
  assign pc1_d_s = pc1_s[27:0];

  // Rotation amount for the step into the next round
  always_comb begin
    next_round_s = round_r + 4'd1;
    if (mode_r) begin
      shift_s = DEC_SHIFT[next_round_s];
    end else begin
      shift_s = ENC_SHIFT[next_round_s];
    end
  end

  des_pc2 u_pc2 (
    .cd     ({c_r, d_r}),
    .subkey (pc2_s)
  );

  // Schedule FSM: load on start, advance C/D on each accepted subkey
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      c_r     <= 28'h0;
      d_r     <= 28'h0;
      round_r <= 4'd0;
      mode_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r  <= decrypt;
            c_r     <= decrypt ? pc1_c_s : rotl(pc1_c_s, 2'd1);
            d_r     <= decrypt ? pc1_d_s : rotl(pc1_d_s, 2'd1);
            round_r <= 4'd0;
            state_r <= EMIT;
          end
        end
        EMIT: begin
          if (subkey_ready) begin
            if (round_r == LAST_ROUND) begin
              state_r <= IDLE;
              round_r <= 4'd0;
              done_r  <= 1'b1;
            end else begin
              round_r <= next_round_s;
              c_r     <= mode_r ? rotr(c_r, shift_s) : rotl(c_r, shift_s);
              d_r     <= mode_r ? rotr(d_r, shift_s) : rotl(d_r, shift_s);
            end
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign subkey_valid = (state_r == EMIT);
  assign busy         = (state_r == EMIT);
  assign done         = done_r;
  assign round_idx    = round_r;
  assign subkey       = (state_r == EMIT) ? pc2_s : 48'h0;

endmodule

// File: tb/tb_des_key_schedule.sv
// Self-checking bench for des_key_schedule against a cumulative-rotation DES key model.
module tb_des_key_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] key_in = 64'h0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        busy;
  logic        done;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  logic [47:0] exp_k [16];
  logic [47:0] obs_k [16];

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SHIFTS [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_in       (key_in),
    .start        (start),
    .decrypt      (decrypt),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Kn = PC2(C0 <<< s, D0 <<< s) with s the sum of the first n shifts
  function automatic logic [47:0] ref_subkey(input logic [63:0] key, input int n);
    logic [55:0] cd0;
    logic [27:0] c0, d0, c, d;
    logic [55:0] cd;
    logic [47:0] k;
    int s;
    cd0 = 56'h0;
    for (int j = 0; j < 56; j++) cd0 = (cd0 << 1) | 56'((key >> (64 - PC1_T[j])) & 64'd1);
    c0 = cd0[55:28];
    d0 = cd0[27:0];
    s = 0;
    for (int r = 0; r < n; r++) s += SHIFTS[r];
    c = 28'h0;
    d = 28'h0;
    for (int b = 0; b < 28; b++) begin
      c = (c << 1) | 28'((c0 >> (27 - ((b + s) % 28))) & 28'd1);
      d = (d << 1) | 28'((d0 >> (27 - ((b + s) % 28))) & 28'd1);
    end
    cd = {c, d};
    k = 48'h0;
    for (int j = 0; j < 48; j++) k = (k << 1) | 48'((cd >> (56 - PC2_T[j])) & 56'd1);
    return k;
  endfunction

  task automatic set_exp(input logic [63:0] key, input logic dec);
    for (int i = 0; i < 16; i++) exp_k[i] = ref_subkey(key, dec ? (16 - i) : (i + 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse start; decrypt and key_in are scrambled afterwards and must not matter
  task automatic start_sched(input logic [63:0] k, input logic dec);
    key_in  = k;
    decrypt = dec;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    decrypt = ~dec;
    key_in  = {$urandom, $urandom};
    check("start_valid", 64'(subkey_valid), 64'd1);
    check("start_idx", 64'(round_idx), 64'd0);
    check("start_busy", 64'(busy), 64'd1);
  endtask

  // ev_kind: 0 none, 1 stall 5 cycles at idx 3, 2 stray start at idx 7
  task automatic collect(input int rmode, input int ev_kind, output int cycles);
    int got;
    int stall;
    bit injected;
    got = 0;
    stall = 0;
    injected = 1'b0;
    cycles = 0;
    while (got < 16 && cycles < 1000) begin
      subkey_ready = (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (ev_kind == 1 && got == 3 && stall < 5) begin
        subkey_ready = 1'b0;
        stall++;
      end
      if (ev_kind == 2 && got == 7 && !injected) begin
        start    = 1'b1;
        key_in   = ~key_in;
        injected = 1'b1;
      end
      check("valid", 64'(subkey_valid), 64'd1);
      check("round_idx", 64'(round_idx), 64'(got));
      check("subkey", 64'(subkey), 64'(exp_k[got]));
      if (subkey_valid === 1'b1 && subkey_ready === 1'b1) begin
        obs_k[got] = subkey;
        got++;
      end
      tick();
      start = 1'b0;
      cycles++;
    end
    subkey_ready = 1'b0;
    check("accept_count", 64'(got), 64'd16);
    check("done_pulse", 64'(done), 64'd1);
    check("valid_in_done", 64'(subkey_valid), 64'd0);
    check("busy_in_done", 64'(busy), 64'd0);
  endtask

  initial begin
    int cyc;
    logic [63:0] k;
    logic [63:0] k2;
    logic dec;

    rst = 1'b1;
    tick();
    tick();
    check("rst_valid", 64'(subkey_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_idx", 64'(round_idx), 64'd0);
    check("rst_subkey", 64'(subkey), 64'd0);
    rst = 1'b0;

    // Ready while idle is ignored
    subkey_ready = 1'b1;
    tick();
    tick();
    check("idle_ready_valid", 64'(subkey_valid), 64'd0);

    k = 64'h133457799BBCDFF1;
    set_exp(k, 1'b0);
    start_sched(k, 1'b0);
    check("enc_k1_const", 64'(subkey), 64'h1B02EFFC7072);
    collect(0, 0, cyc);
    check("enc_cycles", 64'(cyc), 64'd16);
    check("enc_k2_const", 64'(obs_k[1]), 64'h79AED9DBC9E5);
    check("enc_k16_const", 64'(obs_k[15]), 64'hCB3D8B0E17F5);
    tick();
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_subkey_zero", 64'(subkey), 64'd0);

    set_exp(k, 1'b1);
    start_sched(k, 1'b1);
    check("dec_k16_const", 64'(subkey), 64'hCB3D8B0E17F5);
    collect(0, 0, cyc);
    check("dec_last_const", 64'(obs_k[15]), 64'h1B02EFFC7072);
    tick();

    // Backpressure at idx 3, then a random ready pattern
    set_exp(k, 1'b0);
    start_sched(k, 1'b0);
    collect(0, 1, cyc);
    check("stall_cycles", 64'(cyc), 64'd21);
    tick();
    start_sched(k, 1'b0);
    collect(1, 0, cyc);
    tick();

    // Stray start mid-schedule, then back-to-back start in the done cycle
    set_exp(k, 1'b1);
    start_sched(k, 1'b1);
    collect(1, 2, cyc);
    k2 = {$urandom, $urandom};
    set_exp(k2, 1'b1);
    key_in  = k2;
    decrypt = 1'b1;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    decrypt = 1'b0;
    check("b2b_valid", 64'(subkey_valid), 64'd1);
    check("b2b_idx", 64'(round_idx), 64'd0);
    check("b2b_done_low", 64'(done), 64'd0);
    check("b2b_k16", 64'(subkey), 64'(ref_subkey(k2, 16)));
    collect(1, 0, cyc);
    tick();

    // Reset at idx 9 with ready high
    set_exp(k, 1'b0);
    start_sched(k, 1'b0);
    subkey_ready = 1'b1;
    cyc = 0;
    while (round_idx !== 4'd9 && cyc < 100) begin
      tick();
      cyc++;
    end
    check("reach_idx9", 64'(round_idx), 64'd9);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    subkey_ready = 1'b0;
    check("mid_rst_valid", 64'(subkey_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_idx", 64'(round_idx), 64'd0);
    check("mid_rst_subkey", 64'(subkey), 64'd0);
    for (int i = 0; i < 4; i++) begin
      check("mid_rst_no_done", 64'(done), 64'd0);
      tick();
    end

    // rst and start together: rst wins
    key_in = k;
    start  = 1'b1;
    rst    = 1'b1;
    tick();
    start  = 1'b0;
    rst    = 1'b0;
    check("rst_start_valid", 64'(subkey_valid), 64'd0);

    start_sched(k, 1'b0);
    collect(0, 0, cyc);
    tick();

    // Parity bits must not affect the schedule
    for (int m = 0; m < 2; m++) begin
      set_exp(k, 1'(m));
      start_sched(k ^ 64'h0101010101010101, 1'(m));
      collect(1, 0, cyc);
      tick();
    end

    // Random keys and modes
    for (int t = 0; t < 4; t++) begin
      k2  = {$urandom, $urandom};
      dec = 1'($urandom_range(0, 1));
      set_exp(k2, dec);
      start_sched(k2, dec);
      collect(1, 0, cyc);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/des_key_schedule.md
Name: des_key_schedule

Overview:
- Iterative DES subkey generator feeding the round datapath that consumes the S-box outputs.
- Covers the "other direction" of the cipher. Encrypt mode emits K1..K16 using left rotations. Decrypt mode emits K16..K1 using right rotations.
- Emits one 48-bit subkey per accepted valid/ready handshake. The round engine uses it for both encryption and decryption.

Parameters:
- NUM_ROUNDS, 16, number of subkeys emitted per key load; fixed at 16 for DES, used only for counter sizing and checks.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- key_in  in  64  DES key, bit 63 = key bit 1 (FIPS numbering); parity bits ignored
- start  in  1  one-cycle request to load key_in and begin a schedule
- decrypt  in  1  sampled with start; 0 = K1..K16 order, 1 = K16..K1 order
- subkey_ready  in  1  round datapath accepts current subkey
- subkey  out  48  current subkey, bit 47 = PC-2 output bit 1
- subkey_valid  out  1  subkey and round_idx valid
- round_idx  out  4  0..15 index of the subkey being presented, in emission order
- busy  out  1  schedule in progress
- done  out  1  one-cycle pulse after the final subkey is accepted

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=IDLE; C, D, round counter and mode register cleared.
  - subkey_valid=0, busy=0, done=0, round_idx=0.
  - subkey is 48'h0 while state=IDLE.
- FSM states: IDLE and EMIT.
- IDLE:
  - start=1 loads {C,D} = PC1(key_in) and latches decrypt into the mode register.
  - Encrypt loads C,D each rotated left by 1. Decrypt loads them unrotated, because the total rotation of 28 returns to C0/D0, so K16 = PC2(C0,D0).
  - round counter=0; next state EMIT.
- EMIT:
  - subkey = PC2({C,D}), combinational from registers; subkey_valid=1; busy=1; round_idx = round counter.
- Latency: start at edge N gives subkey_valid=1 and round_idx=0 after edge N.
- Handshake:
  - Advance only on subkey_valid & subkey_ready at a clock edge.
  - Without ready, subkey, round_idx, C and D hold stable.
  - ready while not valid is ignored.
- Advance from round r (0..14):
  - Counter becomes r+1.
  - Encrypt: rotate C,D left by ENC_SHIFT[r+1].
  - Decrypt: rotate C,D right by DEC_SHIFT[r+1].
  - ENC_SHIFT = 1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
  - DEC_SHIFT = 0,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1.
- Advance from round 15:
  - Next state IDLE; done=1 for exactly one cycle; subkey_valid=0 in that cycle.
- Back-to-back schedules:
  - start in the done cycle (state IDLE) is honoured; the new schedule's first subkey is valid the next cycle.
  - start while in EMIT is ignored; no abort and no reload.
- decrypt changes after the start cycle have no effect until the next start.
- Rotations are 28-bit circular, independent on C and D; no carry between halves.
- rst during EMIT wins over any handshake in the same cycle; the block returns to reset values next cycle and never asserts done.
- start and rst in the same cycle: rst wins.

Decomposition:
- des_pkg, shared with the round datapath:
  - PC1 table (56 entries) and PC2 table (48 entries) as localparam index arrays.
  - ENC_SHIFT and DEC_SHIFT constants.
  - typedef state_t {IDLE, EMIT}.
  - typedef half_t logic[27:0].
- Sub-module des_pc2:
  - Purely combinational 56->48 bit selection.
  - Reused by a future unrolled key path; PC1 stays inline.

Test Plan:
- Encrypt, key 64'h133457799BBCDFF1, start, ready held 1:
  - round_idx 0 subkey 48'h1B02EFFC7072.
  - round_idx 1 subkey 48'h79AED9DBC9E5.
  - round_idx 15 subkey 48'hCB3D8B0E17F5.
  - done pulses 1 cycle after last accept; 16 consecutive valid cycles.
- Decrypt, same key:
  - round_idx 0 = 48'hCB3D8B0E17F5, round_idx 15 = 48'h1B02EFFC7072.
  - Full sequence equals the encrypt sequence reversed.
- Backpressure, encrypt:
  - ready=0 for 5 cycles at round_idx 3 -> subkey/round_idx stable, valid held.
  - Resumes with the correct round-4 key when ready=1.
  - Random ready pattern yields the identical 16-key sequence.
- Run-time start, decrypt:
  - start with a different key at round_idx 7 -> ignored, sequence unchanged.
  - start in the done cycle -> new schedule's K16 valid the next cycle.
- rst asserted at round_idx 9 with ready=1 -> next cycle valid=0, busy=0, done never pulses.
  - A subsequent start begins at round_idx 0.
- Parity invariance: key_in XOR 64'h0101010101010101 produces a sequence bit-identical to the original key in both modes.
